// File: rtl/fcp_pkg.sv
// Shared FCP master definitions: sequencer state encodings, response status codes,
// UI length and the response record.
package fcp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PING      = 3'd1,
    ST_CMD       = 3'd2,
    ST_RESP_WAIT = 3'd3,
    ST_RETRY_GAP = 3'd4,
    ST_RESET_BUS = 3'd5,
    ST_REPORT    = 3'd6
  } fcp_state_e;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_NACK    = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

  // One unit interval, in clock cycles
  localparam logic [15:0] UI_CYCLE = 16'd20;

  typedef struct packed {
    logic [1:0] status;
    logic [7:0] data;
  } fcp_rsp_t;

endpackage

// File: rtl/fcp_seq_timer.sv
// Loadable down-counter; o_zero flags expiry. A load overrides counting,
// and the count holds at zero until the next load.
module fcp_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                          r_cnt <= '0;
    else if (i_load)                  r_cnt <= i_load_val;
    else if (i_en && (r_cnt != '0))   r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fcp_mst_seq.sv
// FCP master sequencer: PING + CMD transmit, slave response wait with timeout and retry.
// Define FCP_MST_SEQ_BUS_RESET_EN to add a bus reset pulse and hold after retry exhaustion.
module fcp_mst_seq
  import fcp_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd2000,
  parameter logic [1:0]  MAX_RETRY   = 2'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_data,
  output logic        tx_en,
  output logic        tx_type,
  output logic        tx_reset,
  output logic [23:0] tx_data,
  input  logic        tx_done,
  input  logic        rx_valid,
  input  logic        rx_ack,
  input  logic [7:0]  rx_data,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [7:0]  rsp_data,
  output logic        busy
);

`ifdef FCP_MST_SEQ_BUS_RESET_EN
  localparam logic [15:0] BUS_RESET_CYC = 16'd2000;
  logic        r_tx_reset;
  logic        w_rst_pulse;
`endif

  fcp_state_e  r_state, w_nxt;
  logic        r_tx_en, w_tx_en_nxt;
  logic [23:0] r_tx_data;
  fcp_rsp_t    r_rsp;
  logic [1:0]  r_retry;
  logic        w_hs, w_done, w_ok, w_fail, w_nack;
  logic        w_tmr_load, w_tmr_en, w_tmr_zero;
  logic [15:0] w_tmr_val;

  assign w_hs     = cmd_valid && (r_state == ST_IDLE);
  // Only a completion of a transmission we actually started advances the FSM
  assign w_done   = tx_done && r_tx_en;
  assign w_tmr_en = (r_state != ST_IDLE);

  fcp_seq_timer #(.W(16)) u_tmr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    w_tx_en_nxt = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_ok        = 1'b0;
    w_fail      = 1'b0;
    w_nack      = 1'b0;
`ifdef FCP_MST_SEQ_BUS_RESET_EN
    w_rst_pulse = 1'b0;
`endif
    case (r_state)
      ST_IDLE: if (cmd_valid) w_nxt = ST_PING;
      // tx_en is registered, so each transmit state opens with one low cycle
      ST_PING: begin
        w_tx_en_nxt = 1'b1;
        if (w_done) begin
          w_tx_en_nxt = 1'b0;
          w_nxt       = ST_CMD;
        end
      end
      ST_CMD: begin
        w_tx_en_nxt = 1'b1;
        if (w_done) begin
          w_tx_en_nxt = 1'b0;
          w_nxt       = ST_RESP_WAIT;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TIMEOUT_CYC - 16'd1;
        end
      end
      ST_RESP_WAIT: begin
        if (rx_valid) begin
          if (rx_ack) begin
            w_ok  = 1'b1;
            w_nxt = ST_REPORT;
          end else begin
            w_fail = 1'b1;
            w_nack = 1'b1;
          end
        end else if (w_tmr_zero) begin
          w_fail = 1'b1;
        end
        if (w_fail) begin
          if (r_retry < MAX_RETRY) begin
            w_nxt      = ST_RETRY_GAP;
            w_tmr_load = 1'b1;
            w_tmr_val  = UI_CYCLE - 16'd1;
          end else begin
`ifdef FCP_MST_SEQ_BUS_RESET_EN
            w_nxt       = ST_RESET_BUS;
            w_tmr_load  = 1'b1;
            w_tmr_val   = BUS_RESET_CYC - 16'd1;
            w_rst_pulse = 1'b1;
`else
            w_nxt = ST_REPORT;
`endif
          end
        end
      end
      ST_RETRY_GAP: if (w_tmr_zero) w_nxt = ST_PING;
`ifdef FCP_MST_SEQ_BUS_RESET_EN
      ST_RESET_BUS: if (w_tmr_zero) w_nxt = ST_REPORT;
`endif
      ST_REPORT: w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_rsp     <= '0;
      r_retry   <= '0;
    end else begin
      r_tx_en <= w_tx_en_nxt;
      if (w_hs) r_tx_data <= cmd_data;
      if (w_ok) begin
        r_rsp.status <= RSP_OK;
        r_rsp.data   <= rx_data;
      end else if (w_fail) begin
        r_rsp.status <= w_nack ? RSP_NACK : RSP_TIMEOUT;
      end
      if (r_state == ST_REPORT)                  r_retry <= '0;
      else if (w_fail && (r_retry < MAX_RETRY))  r_retry <= r_retry + 2'd1;
    end
  end

`ifdef FCP_MST_SEQ_BUS_RESET_EN
  always_ff @(posedge clk) begin
    if (rst) r_tx_reset <= 1'b0;
    else     r_tx_reset <= w_rst_pulse;
  end
  assign tx_reset = r_tx_reset;
`else
  assign tx_reset = 1'b0;
`endif

  assign cmd_ready  = (r_state == ST_IDLE) && !rst;
  assign busy       = (r_state != ST_IDLE);
  assign tx_en      = r_tx_en;
  assign tx_type    = (r_state == ST_CMD);
  assign tx_data    = r_tx_data;
  assign rsp_valid  = (r_state == ST_REPORT);
  assign rsp_status = r_rsp.status;
  assign rsp_data   = r_rsp.data;

endmodule

// File: doc/fcp_mst_seq.md
FCP_MST_SEQ -- requirements
Module: fcp_mst_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16'd2000, giving the number of cycles to wait for a slave response.
REQ-002 SHALL have parameter MAX_RETRY, default 2'd2, giving the number of re-sends after a failed attempt.
REQ-003 SHALL have port clk, input, 1 bit: single clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1) and cmd_data (input, 24): command handshake; the payload is the {type, addr, data} bytes.
REQ-006 SHALL have ports tx_en, tx_type and tx_reset (outputs, 1 each) and tx_data (output, 24): drive the master TX controller.
REQ-007 SHALL have port tx_done, input, 1: one-cycle pulse from the TX controller at the end of a transmission.
REQ-008 SHALL have ports rx_valid (input, 1), rx_ack (input, 1) and rx_data (input, 8): slave response from the RX path, where rx_ack=1 means ACK and 0 means NACK/parity error.
REQ-009 SHALL have ports rsp_valid (output, 1), rsp_status (output, 2) and rsp_data (output, 8): completion report.
REQ-010 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-011 SHALL implement states IDLE, PING, CMD, RESP_WAIT, RETRY_GAP, RESET_BUS and REPORT.
REQ-012 In IDLE, cmd_ready=1; the handshake completes when cmd_valid&cmd_ready; cmd_data is latched into tx_data in that cycle; the next state is PING.
REQ-013 In PING, tx_type=0 and tx_en=1, starting the cycle after entry; on tx_done, tx_en=0 and the next state is CMD.
REQ-014 In CMD, tx_type=1 and tx_en=1, starting the cycle after entry; on tx_done, tx_en=0, the timeout counter is cleared, and the next state is RESP_WAIT.
REQ-015 tx_en SHALL be low for at least one cycle between any two transmissions, so that the TX controller sees each rising edge.
REQ-016 In RESP_WAIT, rx_valid&rx_ack latches rx_data into rsp_data, sets status 2'b00, and goes to REPORT.
REQ-017 In RESP_WAIT, rx_valid&!rx_ack counts as a failed attempt.
REQ-018 In RESP_WAIT, the counter reaching TIMEOUT_CYC-1 without rx_valid counts as a failed attempt.
REQ-019 If rx_valid arrives in the same cycle as the timeout, rx_valid wins.
REQ-020 On a failed attempt with retry_cnt<MAX_RETRY: increment retry_cnt and go to RETRY_GAP.
REQ-021 On a failed attempt with retry_cnt==MAX_RETRY: go to RESET_BUS if the macro is defined, else to REPORT; status SHALL be 2'b01 if the last failure was a NACK, 2'b10 if it was a timeout.
REQ-022 RETRY_GAP SHALL wait exactly 20 cycles (1 UI) with tx_en=0, then go to PING.
REQ-023 REPORT SHALL pulse rsp_valid for exactly one cycle, clear retry_cnt, and return to IDLE.
REQ-024 Latency: the next command SHALL be acceptable at the earliest 1 cycle after rsp_valid.
REQ-025 rx_valid outside RESP_WAIT SHALL be ignored.
REQ-026 tx_done outside PING/CMD SHALL be ignored.
REQ-027 tx_data SHALL remain stable from the handshake until REPORT.
REQ-028 retry_cnt SHALL be 2 bits and saturate at MAX_RETRY; it SHALL never wrap.
REQ-029 The timeout counter SHALL be 16 bits and SHALL be cleared on every entry to RESP_WAIT.

Reset
REQ-030 While rst=1: state=IDLE, tx_en=0, tx_type=0, tx_reset=0, tx_data=0, rsp_valid=0, rsp_status=0, rsp_data=0, busy=0, cmd_ready=0, and all counters=0.
REQ-031 Reset asserted mid-transaction SHALL abort without producing rsp_valid; cmd_ready SHALL return to 1 the first cycle after rst deasserts.

Configuration
REQ-032 With FCP_MST_SEQ_BUS_RESET_EN defined: on retry exhaustion, RESET_BUS SHALL pulse tx_reset for one cycle, hold tx_en=0 for 2000 cycles, and then go to REPORT with the failure status.
REQ-033 Without FCP_MST_SEQ_BUS_RESET_EN: the RESET_BUS state is absent, tx_reset is tied to 0, and exhaustion goes directly to REPORT.

Structure
REQ-034 The state encodings, the rsp_status codes (OK=2'b00, NACK=2'b01, TIMEOUT=2'b10), and UI_CYCLE=20 SHALL live in shared package fcp_pkg.
REQ-035 The module SHALL be flat except for one sub-module, fcp_seq_timer: a loadable down-counter shared by the RESP_WAIT timeout, the RETRY_GAP wait and the RESET_BUS wait.

Verification
REQ-036 Command 24'h02_3A_55; TX model answers tx_done after 100 cycles each; rx_valid=1, rx_ack=1, rx_data=8'hA5 five cycles into RESP_WAIT -> exactly one rsp_valid with status 00 and data A5; tx_en pulsed twice with tx_type 0 then 1.
REQ-037 Two NACKs followed by an ACK -> three PING+CMD pairs, RETRY_GAP measured at exactly 20 cycles each, final status 00.
REQ-038 No rx_valid ever, macro undefined -> 3 attempts, each RESP_WAIT lasting 2000 cycles, then status 10 and tx_reset never high.
REQ-039 Same as REQ-038 with macro defined -> one tx_reset pulse, 2000 idle cycles, then status 10.
REQ-040 Assert rst during CMD -> tx_en low the next cycle, no rsp_valid; a fresh command after reset completes normally.
REQ-041 rx_valid in the same cycle as the timeout -> response accepted with status 00; spurious tx_done and rx_valid in IDLE -> no state change.
